// File: rtl/pe_mac_v2.sv
// Output-stationary systolic PE: saturating signed/unsigned MAC with operand forwarding
// and a double-buffered, requantised readout chain that drains while the next tile accumulates.
module pe_mac_v2 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_signed,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_valid,
  input  logic              in_first,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  output logic              out_first,
  input  logic              acc_clr,
  input  logic              capture,
  input  logic [4:0]        shift_amt,
  input  logic              chain_en,
  input  logic [OUT_W-1:0]  chain_in,
  output logic [OUT_W-1:0]  chain_out,
  output logic              ovf
);

  generate
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("pe_mac_v2: ACC_W must be >= 2*DATA_W");
    end
  endgenerate

  // Two guard bits above the accumulator hold any acc+prod sum exactly in both modes.
  localparam int WW = ACC_W + 2;
  localparam int RW = ACC_W + 1;

  logic [ACC_W-1:0] acc;
  logic [WW-1:0]    a_w, b_w, prod_w, acc_w, sum_w;
  logic [ACC_W-1:0] sum_sat;
  logic             sum_ovf;

  always_comb begin
    if (mode_signed) begin
      a_w   = {{(WW-DATA_W){in_a[DATA_W-1]}}, in_a};
      b_w   = {{(WW-DATA_W){in_b[DATA_W-1]}}, in_b};
      acc_w = {{2{acc[ACC_W-1]}}, acc};
    end else begin
      a_w   = {{(WW-DATA_W){1'b0}}, in_a};
      b_w   = {{(WW-DATA_W){1'b0}}, in_b};
      acc_w = {2'b00, acc};
    end
    prod_w  = a_w * b_w;
    sum_w   = acc_w + prod_w;
    sum_sat = sum_w[ACC_W-1:0];
    sum_ovf = 1'b0;
    if (mode_signed) begin
      if (sum_w[WW-1:ACC_W-1] != {3{sum_w[WW-1]}}) begin
        sum_ovf = 1'b1;
        sum_sat = sum_w[WW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum_w[WW-1:ACC_W] != 2'b00) begin
      sum_ovf = 1'b1;
      sum_sat = '1;
    end
  end

  logic [4:0]       shift_eff;
  logic [RW-1:0]    acc_x, rnd, rnd_sum, shifted;
  logic [OUT_W-1:0] requant;

  // Round-half-up then shift; an out-of-range shift is clamped rather than wrapped.
  always_comb begin
    shift_eff = (int'(shift_amt) >= ACC_W) ? 5'(ACC_W - 1) : shift_amt;
    acc_x     = mode_signed ? {acc[ACC_W-1], acc} : {1'b0, acc};
    rnd       = (shift_eff == 5'd0) ? '0 : (RW'(1) << (shift_eff - 5'd1));
    rnd_sum   = acc_x + rnd;
    if (mode_signed) shifted = $signed(rnd_sum) >>> shift_eff;
    else             shifted = rnd_sum >> shift_eff;
    requant = shifted[OUT_W-1:0];
    if (mode_signed) begin
      if (shifted[RW-1:OUT_W-1] != {(RW-OUT_W+1){shifted[RW-1]}})
        requant = shifted[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else if (|shifted[RW-1:OUT_W]) begin
      requant = '1;
    end
  end

  // Capture sees acc as registered, so capture+in_first snapshots the tile that just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      chain_out <= '0;
    end else begin
      out_a     <= in_a;
      out_b     <= in_b;
      out_valid <= in_valid;
      out_first <= in_first;
      if (acc_clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (in_valid && in_first) begin
        acc <= prod_w[ACC_W-1:0];
        ovf <= 1'b0;
      end else if (in_valid) begin
        acc <= sum_sat;
        ovf <= ovf | sum_ovf;
      end
      if (capture)       chain_out <= requant;
      else if (chain_en) chain_out <= chain_in;
    end
  end

endmodule
